// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time from a thread and runs it over a
// single memory-controller slot. Define LSU_TIMEOUT_EN to add a WAITING-state watchdog.
module lsu #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  // Request/response: a transfer happens on a clock edge where valid and ready are both 1.
  // A valid source keeps its payload stable until that edge.
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_error,
  output logic                     mem_read_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_WIDTH-1:0]    mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  input  logic                     mem_write_ready,
  output logic [1:0]               lsu_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   op_write;
  logic   side_ready;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("lsu: TIMEOUT_CYCLES must be at least 1");
  end

  assign req_ready  = (state == IDLE);
  assign lsu_state  = state;
  // Only the ready of the side the current op uses is ever looked at.
  assign side_ready = op_write ? mem_write_ready : mem_read_ready;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_count;

  // The op can only enter WAITING from IDLE, so clearing in IDLE clears on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
    end else if (state == IDLE) begin
      wd_count <= '0;
    end else if (state == WAITING) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  assign timeout_hit = (state == WAITING) && !side_ready && (wd_count == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      op_write          <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      resp_error        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_write <= req_write;
            if (req_write) begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= req_addr;
              mem_write_data    <= req_wdata;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= req_addr;
            end
            state <= WAITING;
          end
        end
        WAITING: begin
          if (side_ready) begin
            if (!op_write) begin
              resp_rdata <= mem_read_data;
            end
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            state           <= RELEASE;
          end else if (timeout_hit) begin
            mem_read_valid  <= 1'b0;
            mem_write_valid <= 1'b0;
            resp_error      <= 1'b1;
            state           <= RELEASE;
          end
        end
        RELEASE: begin
          // A controller still holding ready must not see the next op's valid.
          if (!side_ready) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed scenarios plus randomized ops, with a memory-controller model,
// a reference memory and expected-response queues.
`timescale 1ns/1ps
module tb_lsu;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 8;
`ifdef LSU_TIMEOUT_EN
  localparam int WAIT_CHECK = 4;
`else
  localparam int WAIT_CHECK = 100;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          resp_error;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready = 1'b0;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_write_valid;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_ready = 1'b0;
  logic [1:0]    lsu_state;

  int checks = 0;
  int errors = 0;

  logic [DW:0]    exp_q[$];      // {error, rdata}
  logic [AW+DW:0] exp_mem_q[$];  // {write, addr, data}
  logic [DW-1:0]  ref_mem[256];
  logic [DW-1:0]  ctl_mem[256];
  logic [DW-1:0]  last_rdata;

  bit ctl_enable = 1'b1;
  int force_lat = -1;
  int force_hold = -1;
  int rr_mode = 0;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .lsu_state(lsu_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, lsu_state, 0);
    check({tag, "_mem_valid"}, {mem_read_valid, mem_write_valid}, 0);
    check({tag, "_mem_addr"}, {mem_read_address, mem_write_address}, 0);
    check({tag, "_wdata"}, mem_write_data, 0);
    check({tag, "_resp"}, {resp_valid, resp_error, resp_rdata}, 0);
    check({tag, "_req_ready"}, req_ready, 1);
  endtask

  // ---------------- memory controller model ----------------
  int            ph = 0;
  int            lat = 0;
  int            hold = 0;
  logic          cur_wr;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;

  task automatic raise_ready();
    logic [AW+DW:0] e;
    check("mem_q_nonempty", exp_mem_q.size() != 0, 1);
    if (exp_mem_q.size() != 0) begin
      e = exp_mem_q.pop_front();
      check("mem_op", {cur_wr, cur_addr, cur_wr ? cur_data : DW'(0)}, e);
    end
    if (cur_wr) begin
      ctl_mem[cur_addr] = cur_data;
      mem_write_ready = 1'b1;
    end else begin
      mem_read_data  = ctl_mem[cur_addr];
      mem_read_ready = 1'b1;
    end
    ph = 2;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mem_read_ready  = 1'b0;
      mem_write_ready = 1'b0;
      ph = 0;
    end else begin
      check("valid_excl", mem_read_valid && mem_write_valid, 0);
      case (ph)
        0: begin
          mem_read_data = DW'($urandom);
          if (ctl_enable && (mem_read_valid || mem_write_valid)) begin
            cur_wr   = mem_write_valid;
            cur_addr = mem_write_valid ? mem_write_address : mem_read_address;
            cur_data = mem_write_data;
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            if (lat == 0) raise_ready();
            else ph = 1;
          end
        end
        1: begin
          check("valid_held", cur_wr ? mem_write_valid : mem_read_valid, 1);
          check("addr_stable", cur_wr ? mem_write_address : mem_read_address, cur_addr);
          if (cur_wr) check("data_stable", mem_write_data, cur_data);
          lat--;
          if (lat == 0) raise_ready();
        end
        2: begin
          check("valid_drop", {mem_read_valid, mem_write_valid}, 0);
          check("state_release", lsu_state, 2);
          if (!cur_wr) mem_read_data = DW'($urandom);
          hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 4));
          if (hold == 0) begin
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            ph = 0;
          end else begin
            ph = 3;
          end
        end
        default: begin
          check("release_hold", lsu_state, 2);
          check("resp_early", resp_valid, 0);
          hold--;
          if (hold == 0) begin
            mem_read_ready  = 1'b0;
            mem_write_ready = 1'b0;
            ph = 0;
          end
        end
      endcase
    end
  end

  // ---------------- response monitor / scoreboard ----------------
  int          low_cnt = 0;
  bit          prev_hold = 1'b0;
  logic [DW:0] prev_resp;

  always @(negedge clk) begin
    logic [DW:0] e;
    if (reset) begin
      resp_ready = 1'b0;
      prev_hold  = 1'b0;
      low_cnt    = 0;
    end else begin
      if (prev_hold) check("resp_held", {resp_valid, resp_error, resp_rdata}, {1'b1, prev_resp});
      case (rr_mode)
        0: resp_ready = 1'b1;
        1: resp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (resp_valid && low_cnt < 5) begin
            resp_ready = 1'b0;
            low_cnt++;
          end else begin
            resp_ready = (low_cnt >= 5);
          end
        end
      endcase
      if (resp_valid && resp_ready) begin
        check("resp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("resp", {resp_error, resp_rdata}, e);
        end
        low_cnt = 0;
      end
      prev_hold = resp_valid && !resp_ready;
      prev_resp = {resp_error, resp_rdata};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit exp_resp);
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    if (ctl_enable) exp_mem_q.push_back({w, a, w ? d : DW'(0)});
    if (exp_resp) begin
      if (w) begin
        exp_q.push_back({1'b0, last_rdata});
        ref_mem[a] = d;
      end else begin
        last_rdata = ref_mem[a];
        exp_q.push_back({1'b0, last_rdata});
      end
    end
  endtask

  // Junk requests while busy must be ignored; at most two keeps them off an IDLE edge.
  task automatic finish_op();
    int j = int'($urandom_range(0, 2));
    @(negedge clk);
    repeat (j) begin
      req_valid = 1'b1;
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || lsu_state != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < 400, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] lat_exp[5];
    int n;
    lat_exp = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = DW'($urandom);
      ctl_mem[i] = ref_mem[i];
    end
    last_rdata = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_init");
    reset = 1'b0;

    // Minimum-latency load: state sequence after the accept edge
    force_lat = 0; force_hold = 1; rr_mode = 0;
    start_op(1'b0, 8'h05, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      check("latency_state", lsu_state, lat_exp[k]);
    end
    drain();

    // Load 0x10 returning 0xA5 after 3 cycles
    ref_mem[8'h10] = 8'hA5; ctl_mem[8'h10] = 8'hA5;
    force_lat = 3; force_hold = 0;
    start_op(1'b0, 8'h10, 8'h00, 1'b1);
    finish_op();
    drain();
    check("load_a5_rdata", resp_rdata, 8'hA5);

    // Store 0x22 <- 0x5C
    force_lat = 2;
    start_op(1'b1, 8'h22, 8'h5C, 1'b1);
    finish_op();
    drain();

    // Controller holds read ready 4 cycles after the valid drop
    force_lat = 1; force_hold = 4;
    start_op(1'b0, 8'h22, 8'h00, 1'b1);
    finish_op();
    drain();

    // Back-to-back load then store, then a response held off for 5 cycles
    force_lat = -1; force_hold = -1; rr_mode = 0;
    start_op(1'b0, 8'h31, 8'h00, 1'b1);
    finish_op();
    start_op(1'b1, 8'h31, 8'h77, 1'b1);
    finish_op();
    drain();
    rr_mode = 2;
    start_op(1'b0, 8'h31, 8'h00, 1'b1);
    finish_op();
    drain();
    rr_mode = 0;

    // Reset while WAITING abandons the op
    ctl_enable = 1'b0;
    start_op(1'b0, 8'h33, 8'h00, 1'b0);
    finish_op();
    repeat (WAIT_CHECK) begin
      check("waiting_hold", {lsu_state, mem_read_valid}, {2'd1, 1'b1});
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rdata = '0;
    check_idle_outputs("reset_mid");
    ctl_enable = 1'b1;
    start_op(1'b0, 8'h33, 8'h00, 1'b1);
    finish_op();
    drain();

`ifdef LSU_TIMEOUT_EN
    // Watchdog: no ready at all
    ctl_enable = 1'b0;
    start_op(1'b0, 8'h44, 8'h00, 1'b0);
    exp_q.push_back({1'b1, last_rdata});
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (lsu_state == 2'd1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, TO);
    check("timeout_valid_drop", mem_read_valid, 0);
    drain();
    ctl_enable = 1'b1;
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      rr_mode = int'($urandom_range(0, 2));
      start_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom), 1'b1);
      finish_op();
    end
    rr_mode = 0;
    drain();

    check("resp_q_empty", exp_q.size(), 0);
    check("mem_q_empty", exp_mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
